// File: rtl/alu_fault_injector.sv
// ---------------------------------------------------------------------------
// alu_fault_injector
//
// Fault-injection controller for the nine-replica voted ALU. It produces
// per-replica AND/OR/XOR corruption masks. The masks sit between each
// replica's result bus and the voter. A run injects a programmed number of
// faults with a programmed idle spacing between them. Each fault goes either
// to a fixed replica/bit or to one picked by a free-running LFSR.
//
// Parameters:
//   WIDTH  result width per replica
//   NREP   replica count (at most 16)
//   SEED   LFSR reset value (must be nonzero)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   start      launch request, only looked at while idle
//   clear      synchronous return of stuck masks to pass-through
//   cfg_lane   fixed target replica
//   cfg_bit    fixed target bit
//   cfg_mode   00 stuck-at-0, 01 stuck-at-1, 10 one-cycle flip, 11 illegal
//   cfg_rand   take lane/bit from the LFSR instead of cfg_lane/cfg_bit
//   cfg_count  number of faults to inject (0 is illegal)
//   cfg_gap    idle cycles before each injection
//   and_mask   replica r owns bits [r*WIDTH +: WIDTH]; 0 forces a bit low
//   or_mask    1 forces a bit high
//   xor_mask   1 inverts a bit
//   busy       high whenever the controller is not idle
//   done       one-cycle pulse at the end of a run
//   err        one-cycle pulse when a start is rejected
//   inj_count  faults injected since reset, wraps
// ---------------------------------------------------------------------------
module alu_fault_injector #(
    parameter int          WIDTH = 32,
    parameter int          NREP  = 9,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  clear,
    input  logic [3:0]            cfg_lane,
    input  logic [4:0]            cfg_bit,
    input  logic [1:0]            cfg_mode,
    input  logic                  cfg_rand,
    input  logic [7:0]            cfg_count,
    input  logic [15:0]           cfg_gap,
    output logic [NREP*WIDTH-1:0] and_mask,
    output logic [NREP*WIDTH-1:0] or_mask,
    output logic [NREP*WIDTH-1:0] xor_mask,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           inj_count
);

    localparam int          TOTAL     = NREP * WIDTH;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [1:0]  MODE_SA0  = 2'b00;
    localparam logic [1:0]  MODE_SA1  = 2'b01;
    localparam logic [1:0]  MODE_FLIP = 2'b10;
    localparam logic [1:0]  MODE_BAD  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        INJECT,
        DONE
    } state_t;

    state_t      state;
    logic [3:0]  lat_lane;
    logic [4:0]  lat_bit;
    logic [1:0]  lat_mode;
    logic        lat_rand;
    logic [15:0] lat_gap;
    logic [7:0]  remaining;
    logic [15:0] gap_cnt;
    logic [15:0] lfsr;

    logic             cfg_illegal;
    logic [3:0]       tgt_lane;
    logic [4:0]       tgt_bit;
    logic [31:0]      tgt_idx;
    logic [TOTAL-1:0] tgt_onehot;
    logic [TOTAL-1:0] and_next;
    logic [TOTAL-1:0] or_next;
    logic [TOTAL-1:0] xor_next;

    // A start is refused when the mode is the reserved encoding, when no
    // faults are requested, or when a fixed lane names a replica that does
    // not exist. A random lane is always folded into range, so cfg_lane
    // is ignored in that case.
    always_comb begin
        cfg_illegal = (cfg_mode == MODE_BAD) ||
                      (cfg_count == 8'd0) ||
                      (!cfg_rand && (32'(cfg_lane) >= 32'(NREP)));
    end

    // Pick the target replica and bit for the current INJECT cycle. In
    // random mode the low nibble of the LFSR can exceed the replica count.
    // In that case it is folded back by one subtraction, which is enough
    // because NREP is at least half of 16 for the voted ALU. The result is
    // turned into a one-hot vector over the flattened mask buses.
    always_comb begin
        tgt_lane = lat_lane;
        tgt_bit  = lat_bit;
        if (lat_rand) begin
            tgt_bit = lfsr[8:4];
            if (32'(lfsr[3:0]) >= 32'(NREP)) begin
                tgt_lane = lfsr[3:0] - 4'(NREP);
            end else begin
                tgt_lane = lfsr[3:0];
            end
        end
        tgt_idx    = 32'(tgt_lane) * 32'(WIDTH) + 32'(tgt_bit);
        tgt_onehot = {{(TOTAL-1){1'b0}}, 1'b1} << tgt_idx;
    end

    // Next value of the three masks. A clear is applied before any fault
    // landing in the same cycle, so that fault survives the clear. Flips
    // never persist: xor_mask falls back to zero on every cycle that is
    // not an INJECT of a flip.
    always_comb begin
        and_next = clear ? {TOTAL{1'b1}} : and_mask;
        or_next  = clear ? {TOTAL{1'b0}} : or_mask;
        xor_next = {TOTAL{1'b0}};
        if (state == INJECT) begin
            case (lat_mode)
                MODE_SA0: begin
                    and_next = and_next & ~tgt_onehot;
                    or_next  = or_next & ~tgt_onehot;
                end
                MODE_SA1: begin
                    and_next = and_next | tgt_onehot;
                    or_next  = or_next | tgt_onehot;
                end
                MODE_FLIP: begin
                    xor_next = tgt_onehot;
                end
                default: begin
                end
            endcase
        end
    end

    // Sequencer. All outputs are registered here, so nothing reaches the
    // outputs combinationally from the inputs. The LFSR runs in every state.
    // The pattern of random targets therefore depends only on how many
    // cycles have passed since reset, which keeps runs repeatable. busy is
    // set on the accepting edge and cleared on the edge that leaves DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            lat_lane  <= 4'd0;
            lat_bit   <= 5'd0;
            lat_mode  <= MODE_SA0;
            lat_rand  <= 1'b0;
            lat_gap   <= 16'd0;
            remaining <= 8'd0;
            gap_cnt   <= 16'd0;
            lfsr      <= SEED;
            and_mask  <= {TOTAL{1'b1}};
            or_mask   <= {TOTAL{1'b0}};
            xor_mask  <= {TOTAL{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            inj_count <= 16'd0;
        end else begin
            lfsr     <= (lfsr >> 1) ^ ({16{lfsr[0]}} & LFSR_TAPS);
            and_mask <= and_next;
            or_mask  <= or_next;
            xor_mask <= xor_next;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_illegal) begin
                            err <= 1'b1;
                        end else begin
                            lat_lane  <= cfg_lane;
                            lat_bit   <= cfg_bit;
                            lat_mode  <= cfg_mode;
                            lat_rand  <= cfg_rand;
                            lat_gap   <= cfg_gap;
                            remaining <= cfg_count;
                            gap_cnt   <= cfg_gap;
                            busy      <= 1'b1;
                            state     <= (cfg_gap == 16'd0) ? INJECT : GAP;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 16'd1;
                    if (gap_cnt == 16'd1) begin
                        state <= INJECT;
                    end
                end
                INJECT: begin
                    inj_count <= inj_count + 16'd1;
                    remaining <= remaining - 8'd1;
                    if (remaining == 8'd1) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        gap_cnt <= lat_gap;
                        state   <= (lat_gap == 16'd0) ? INJECT : GAP;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_fault_injector.sv
// ---------------------------------------------------------------------------
// tb_alu_fault_injector
//
// Self-checking bench for alu_fault_injector. The expected mask state is
// kept as plain bit vectors. Injections are placed in time from the
// "fault i lands at E0 + i*(G+1)" rule. Random targets come from the LFSR
// value after a given number of clock edges since reset.
// ---------------------------------------------------------------------------
module tb_alu_fault_injector;

    localparam int          WIDTH = 32;
    localparam int          NREP  = 9;
    localparam int          TOTAL = WIDTH * NREP;
    localparam logic [15:0] SEED  = 16'hACE1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             clear = 1'b0;
    logic [3:0]       cfg_lane = 4'd0;
    logic [4:0]       cfg_bit = 5'd0;
    logic [1:0]       cfg_mode = 2'd0;
    logic             cfg_rand = 1'b0;
    logic [7:0]       cfg_count = 8'd0;
    logic [15:0]      cfg_gap = 16'd0;
    logic [TOTAL-1:0] and_mask;
    logic [TOTAL-1:0] or_mask;
    logic [TOTAL-1:0] xor_mask;
    logic             busy;
    logic             done;
    logic             err;
    logic [15:0]      inj_count;

    int               checks = 0;
    int               failures = 0;
    int               edges;
    logic [TOTAL-1:0] exp_and;
    logic [TOTAL-1:0] exp_or;
    logic [15:0]      exp_count;

    alu_fault_injector #(
        .WIDTH(WIDTH),
        .NREP (NREP),
        .SEED (SEED)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .clear    (clear),
        .cfg_lane (cfg_lane),
        .cfg_bit  (cfg_bit),
        .cfg_mode (cfg_mode),
        .cfg_rand (cfg_rand),
        .cfg_count(cfg_count),
        .cfg_gap  (cfg_gap),
        .and_mask (and_mask),
        .or_mask  (or_mask),
        .xor_mask (xor_mask),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .inj_count(inj_count)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Count clock edges since reset was last released. The expected LFSR
    // value is a pure function of this count.
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    // LFSR contents after n edges from the seed.
    function automatic logic [15:0] lfsr_after(input int n);
        logic [15:0] l;
        l = SEED;
        for (int s = 0; s < n; s++) begin
            l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        end
        return l;
    endfunction

    // Hold the design in reset and check every output's reset value.
    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (and_mask !== {TOTAL{1'b1}}) begin
            failures++; $display("[TB] FAIL reset_and_mask: got %h expected all ones", and_mask);
        end
        checks++;
        if (or_mask !== {TOTAL{1'b0}}) begin
            failures++; $display("[TB] FAIL reset_or_mask: got %h expected zero", or_mask);
        end
        checks++;
        if (xor_mask !== {TOTAL{1'b0}}) begin
            failures++; $display("[TB] FAIL reset_xor_mask: got %h expected zero", xor_mask);
        end
        checks++;
        if ({busy, done, err} !== 3'b000) begin
            failures++; $display("[TB] FAIL reset_flags: busy/done/err got %b expected 000", {busy, done, err});
        end
        checks++;
        if (inj_count !== 16'd0) begin
            failures++; $display("[TB] FAIL reset_inj_count: got %0d expected 0", inj_count);
        end
        reset     = 1'b0;
        exp_and   = {TOTAL{1'b1}};
        exp_or    = {TOTAL{1'b0}};
        exp_count = 16'd0;
    endtask

    // Launch one legal run and check every output on every cycle until the
    // controller is idle again. cfg_* is scrambled right after the accepting
    // edge, so a design that fails to latch the config shows up here.
    task automatic test_sequence(input string name, input int lane, input int bitn,
                                 input int mode, input bit rnd, input int count,
                                 input int gap);
        int               period;
        int               last;
        int               k;
        int               ln;
        logic [15:0]      lf;
        logic [TOTAL-1:0] exp_xor;
        period = gap + 1;
        last   = count * period;
        @(negedge clk);
        cfg_lane  = 4'(lane);
        cfg_bit   = 5'(bitn);
        cfg_mode  = 2'(mode);
        cfg_rand  = rnd;
        cfg_count = 8'(count);
        cfg_gap   = 16'(gap);
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        cfg_lane  = 4'($urandom_range(0, 15));
        cfg_bit   = 5'($urandom_range(0, 31));
        cfg_mode  = 2'($urandom_range(0, 3));
        cfg_rand  = 1'($urandom_range(0, 1));
        cfg_count = 8'($urandom_range(0, 255));
        cfg_gap   = 16'($urandom_range(0, 7));
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("[TB] FAIL %s busy_rise: got %b expected 1", name, busy);
        end
        for (int j = 1; j <= last + 1; j++) begin
            @(negedge clk);
            exp_xor = {TOTAL{1'b0}};
            if ((j % period) == 0 && j <= last) begin
                if (rnd) begin
                    lf = lfsr_after(edges - 1);
                    ln = int'(lf[3:0]);
                    if (ln >= NREP) ln = ln - NREP;
                    k = ln * WIDTH + int'(lf[8:4]);
                end else begin
                    k = lane * WIDTH + bitn;
                end
                case (mode)
                    0:       begin exp_and[k] = 1'b0; exp_or[k] = 1'b0; end
                    1:       begin exp_and[k] = 1'b1; exp_or[k] = 1'b1; end
                    default: exp_xor[k] = 1'b1;
                endcase
                exp_count = exp_count + 16'd1;
            end
            checks++;
            if (and_mask !== exp_and) begin
                failures++; $display("[TB] FAIL %s j=%0d and_mask: got %h expected %h", name, j, and_mask, exp_and);
            end
            checks++;
            if (or_mask !== exp_or) begin
                failures++; $display("[TB] FAIL %s j=%0d or_mask: got %h expected %h", name, j, or_mask, exp_or);
            end
            checks++;
            if (xor_mask !== exp_xor) begin
                failures++; $display("[TB] FAIL %s j=%0d xor_mask: got %h expected %h", name, j, xor_mask, exp_xor);
            end
            checks++;
            if (busy !== (j <= last)) begin
                failures++; $display("[TB] FAIL %s j=%0d busy: got %b expected %b", name, j, busy, (j <= last));
            end
            checks++;
            if (done !== (j == last)) begin
                failures++; $display("[TB] FAIL %s j=%0d done: got %b expected %b", name, j, done, (j == last));
            end
            checks++;
            if (err !== 1'b0) begin
                failures++; $display("[TB] FAIL %s j=%0d err: got %b expected 0", name, j, err);
            end
            checks++;
            if (inj_count !== exp_count) begin
                failures++; $display("[TB] FAIL %s j=%0d inj_count: got %0d expected %0d", name, j, inj_count, exp_count);
            end
        end
    endtask

    // Three rejected starts: out-of-range fixed lane, zero count, and the
    // reserved mode. Each must pulse err once and touch nothing else.
    task automatic test_illegal();
        logic [3:0] lanes  [3];
        logic [7:0] counts [3];
        logic [1:0] modes  [3];
        lanes  = '{4'd9, 4'd1, 4'd2};
        counts = '{8'd1, 8'd0, 8'd2};
        modes  = '{2'd0, 2'd1, 2'd3};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            cfg_lane  = lanes[i];
            cfg_bit   = 5'd4;
            cfg_mode  = modes[i];
            cfg_rand  = 1'b0;
            cfg_count = counts[i];
            cfg_gap   = 16'd1;
            start     = 1'b1;
            @(negedge clk);
            start = 1'b0;
            checks++;
            if (err !== 1'b1) begin
                failures++; $display("[TB] FAIL illegal%0d err_pulse: got %b expected 1", i, err);
            end
            checks++;
            if (busy !== 1'b0) begin
                failures++; $display("[TB] FAIL illegal%0d busy: got %b expected 0", i, busy);
            end
            checks++;
            if (and_mask !== exp_and || or_mask !== exp_or || xor_mask !== {TOTAL{1'b0}}) begin
                failures++; $display("[TB] FAIL illegal%0d masks: and %h or %h xor %h expected unchanged", i, and_mask, or_mask, xor_mask);
            end
            @(negedge clk);
            checks++;
            if ({err, busy, inj_count} !== {1'b0, 1'b0, exp_count}) begin
                failures++; $display("[TB] FAIL illegal%0d after: err %b busy %b inj %0d expected 0 0 %0d", i, err, busy, inj_count, exp_count);
            end
        end
    endtask

    // Reset arrives in the middle of a gap, after a stuck-at-0 has landed.
    // The effect must be immediate, without waiting for a clock edge.
    task automatic test_reset_mid_gap();
        logic [TOTAL-1:0] want_and;
        logic [TOTAL-1:0] want_or;
        @(negedge clk);
        cfg_lane = 4'd1; cfg_bit = 5'd2; cfg_mode = 2'd0; cfg_rand = 1'b0;
        cfg_count = 8'd3; cfg_gap = 16'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        want_and = exp_and; want_and[34] = 1'b0;
        want_or  = exp_or;  want_or[34]  = 1'b0;
        checks++;
        if (and_mask !== want_and || or_mask !== want_or) begin
            failures++; $display("[TB] FAIL midgap_pre_fault: and %h or %h expected and %h or %h", and_mask, or_mask, want_and, want_or);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (and_mask !== {TOTAL{1'b1}} || or_mask !== {TOTAL{1'b0}} || xor_mask !== {TOTAL{1'b0}}) begin
            failures++; $display("[TB] FAIL midgap_masks: and %h or %h xor %h expected reset values", and_mask, or_mask, xor_mask);
        end
        checks++;
        if (busy !== 1'b0 || inj_count !== 16'd0) begin
            failures++; $display("[TB] FAIL midgap_state: busy %b inj %0d expected 0 0", busy, inj_count);
        end
        @(negedge clk);
        reset     = 1'b0;
        exp_and   = {TOTAL{1'b1}};
        exp_or    = {TOTAL{1'b0}};
        exp_count = 16'd0;
        test_sequence("after_reset_rand", 0, 0, 1, 1'b1, 4, 1);
    endtask

    // Earlier stuck faults exist. A start pulsed during GAP must be ignored.
    // A clear in the same cycle as the INJECT must wipe the old faults and
    // keep the new stuck-at-1 on lane 0, bit 0.
    task automatic test_clear_with_inject();
        logic [TOTAL-1:0] want_or;
        test_sequence("prep_sa0", 2, 7, 0, 1'b0, 1, 0);
        test_sequence("prep_sa1", 5, 9, 1, 1'b0, 2, 1);
        want_or    = {TOTAL{1'b0}};
        want_or[0] = 1'b1;
        @(negedge clk);
        cfg_lane = 4'd0; cfg_bit = 5'd0; cfg_mode = 2'd1; cfg_rand = 1'b0;
        cfg_count = 8'd1; cfg_gap = 16'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        cfg_mode = 2'd3;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("[TB] FAIL gap_start_ignored: err %b busy %b expected 0 1", err, busy);
        end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (and_mask !== {TOTAL{1'b1}}) begin
            failures++; $display("[TB] FAIL clear_inject_and: got %h expected all ones", and_mask);
        end
        checks++;
        if (or_mask !== want_or) begin
            failures++; $display("[TB] FAIL clear_inject_or: got %h expected %h", or_mask, want_or);
        end
        checks++;
        if (done !== 1'b1 || inj_count !== exp_count + 16'd1) begin
            failures++; $display("[TB] FAIL clear_inject_done: done %b inj %0d expected 1 %0d", done, inj_count, exp_count + 16'd1);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || or_mask !== want_or) begin
            failures++; $display("[TB] FAIL clear_inject_end: busy %b or %h expected 0 %h", busy, or_mask, want_or);
        end
        exp_and   = {TOTAL{1'b1}};
        exp_or    = want_or;
        exp_count = exp_count + 16'd1;
    endtask

    // A handful of random legal configurations, launched back to back.
    task automatic test_random_configs();
        for (int i = 0; i < 8; i++) begin
            test_sequence($sformatf("rand_cfg%0d", i),
                          int'($urandom_range(0, NREP - 1)), int'($urandom_range(0, 31)),
                          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_sequence("fixed_sa1_l3_b5", 3, 5, 1, 1'b0, 1, 0);
        test_sequence("fixed_flip_l8_b31", 8, 31, 2, 1'b0, 3, 2);
        test_illegal();
        test_reset_mid_gap();
        test_sequence("random_sa0_200", 0, 0, 0, 1'b1, 200, 0);
        test_clear_with_inject();
        test_random_configs();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hang anywhere in the sequence above.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
